// File: rtl/riscv_alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, FSM states, op decode.
package riscv_alu_pkg;

    localparam int WIDTH = 32;
    localparam int CTL_W = 4;

    localparam logic [CTL_W-1:0] ALU_AND = 4'd0;
    localparam logic [CTL_W-1:0] ALU_OR  = 4'd1;
    localparam logic [CTL_W-1:0] ALU_ADD = 4'd2;
    localparam logic [CTL_W-1:0] ALU_SUB = 4'd6;
    localparam logic [CTL_W-1:0] ALU_SLT = 4'd7;
    localparam logic [CTL_W-1:0] ALU_NOR = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_supported_op(input logic [CTL_W-1:0] ctl);
        case (ctl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_alu_arbiter_if.sv
// Requester handshakes, shared response bus and ALU hookup for the arbiter.
interface riscv_alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CTL_W = 4
);
    logic             r0_req_valid;
    logic             r0_req_ready;
    logic [CTL_W-1:0] r0_ctl;
    logic [WIDTH-1:0] r0_a;
    logic [WIDTH-1:0] r0_b;
    logic             r0_rsp_valid;
    logic             r0_rsp_ready;

    logic             r1_req_valid;
    logic             r1_req_ready;
    logic [CTL_W-1:0] r1_ctl;
    logic [WIDTH-1:0] r1_a;
    logic [WIDTH-1:0] r1_b;
    logic             r1_rsp_valid;
    logic             r1_rsp_ready;

    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_err;

    logic [CTL_W-1:0] alu_ctl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_out;

    logic             busy;

    // Arbiter side
    modport slave (
        input  r0_req_valid, r0_ctl, r0_a, r0_b, r0_rsp_ready,
        input  r1_req_valid, r1_ctl, r1_a, r1_b, r1_rsp_ready,
        input  alu_out,
        output r0_req_ready, r0_rsp_valid,
        output r1_req_ready, r1_rsp_valid,
        output rsp_data, rsp_zero, rsp_err,
        output alu_ctl, alu_a, alu_b,
        output busy
    );

    // Requester / ALU side
    modport master (
        output r0_req_valid, r0_ctl, r0_a, r0_b, r0_rsp_ready,
        output r1_req_valid, r1_ctl, r1_a, r1_b, r1_rsp_ready,
        output alu_out,
        input  r0_req_ready, r0_rsp_valid,
        input  r1_req_ready, r1_rsp_valid,
        input  rsp_data, rsp_zero, rsp_err,
        input  alu_ctl, alu_a, alu_b,
        input  busy
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer remembers who was served last.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       update,
    output logic [1:0] grant
);
    logic last_grant_q;
    logic last_grant_d;

    // Lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant        = 2'b00;
        last_grant_d = last_grant_q;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (update) begin
            last_grant_d = grant[1];
        end
    end

    // Pointer starts at 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: rtl/riscv_alu_arbiter.sv
// Shares one combinational ALU between the datapath (r0) and the
// branch/address unit (r1). One operation in flight at a time; the
// registered response is held until its owner takes it.
module riscv_alu_arbiter
    import riscv_alu_pkg::*;
#(
    parameter int WIDTH = riscv_alu_pkg::WIDTH,
    parameter int CTL_W = riscv_alu_pkg::CTL_W
) (
    input  logic                 clk,
    input  logic                 reset,
    riscv_alu_arbiter_if.slave   bus
);
    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic [CTL_W-1:0] ctl_q, ctl_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;

    logic [1:0]       req_valid;
    logic [1:0]       grant;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic             accept;
    logic [WIDTH-1:0] result;

    assign req_valid = {bus.r1_req_valid, bus.r0_req_valid};

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid  (req_valid),
        .update (accept),
        .grant  (grant)
    );

    // Next state, operand capture and response capture.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ctl_d      = ctl_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        accept     = 1'b0;
        result     = '0;

        case (state_q)
            IDLE: begin
                // Ready is held low while reset is asserted.
                if (!reset) begin
                    req_ready = grant;
                    accept    = (grant != 2'b00);
                end
                if (accept) begin
                    owner_d = grant[1];
                    ctl_d   = grant[1] ? bus.r1_ctl : bus.r0_ctl;
                    a_d     = grant[1] ? bus.r1_a   : bus.r0_a;
                    b_d     = grant[1] ? bus.r1_b   : bus.r0_b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Unsupported codes ignore whatever the ALU produces.
                if (is_supported_op(ctl_q)) begin
                    result    = bus.alu_out;
                    rsp_err_d = 1'b0;
                end else begin
                    result    = '0;
                    rsp_err_d = 1'b1;
                end
                rsp_data_d = result;
                rsp_zero_d = (result == '0);
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (owner_q ? bus.r1_rsp_ready : bus.r0_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            ctl_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ctl_q      <= ctl_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // ALU inputs always come from the latched request so its output is stable.
    assign bus.alu_ctl      = ctl_q;
    assign bus.alu_a        = a_q;
    assign bus.alu_b        = b_q;

    assign bus.r0_req_ready = req_ready[0];
    assign bus.r1_req_ready = req_ready[1];
    assign bus.r0_rsp_valid = rsp_valid[0];
    assign bus.r1_rsp_valid = rsp_valid[1];
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// Directed bench for riscv_alu_arbiter with a reference ALU on the alu_* port
// and a response scoreboard filled at request acceptance.
module tb_riscv_alu_arbiter;
    import riscv_alu_pkg::*;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        logic        zero;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   grants[$];

    always #5 clk = ~clk;

    riscv_alu_arbiter_if #(.WIDTH(32), .CTL_W(4)) bus ();

    riscv_alu_arbiter #(.WIDTH(32), .CTL_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        case (ctl)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return (a < b) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Reference ALU; garbage on unknown codes so the arbiter must mask it.
    always_comb bus.alu_out = alu_fn(bus.alu_ctl, bus.alu_a, bus.alu_b);

    function automatic exp_t make_exp(input logic who, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.owner = who;
        case (ctl)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: begin e.data = alu_fn(ctl, a, b); e.err = 1'b0; end
            default:                              begin e.data = 32'd0;             e.err = 1'b1; end
        endcase
        e.zero = (e.data == 32'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input logic who);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("rsp_owner", {31'd0, who}, {31'd0, e.owner});
            chk("rsp_data", bus.rsp_data, e.data);
            chk("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, e.zero});
            chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        end
    endtask

    // Sample point: mid-cycle, records request and response handshakes.
    task automatic to_sample();
        @(negedge clk);
        #1;
        chk("ready_onehot", {31'd0, bus.r0_req_ready & bus.r1_req_ready}, 32'd0);
        if (bus.r0_req_valid && bus.r0_req_ready) begin
            sb.push_back(make_exp(1'b0, bus.r0_ctl, bus.r0_a, bus.r0_b));
            grants.push_back(0);
        end
        if (bus.r1_req_valid && bus.r1_req_ready) begin
            sb.push_back(make_exp(1'b1, bus.r1_ctl, bus.r1_a, bus.r1_b));
            grants.push_back(1);
        end
        if (bus.r0_rsp_valid && bus.r0_rsp_ready) pop_check(1'b0);
        if (bus.r1_rsp_valid && bus.r1_rsp_ready) pop_check(1'b1);
    endtask

    // Drive point: just after the rising edge.
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        to_sample();
        to_drive();
    endtask

    task automatic set_req(input logic who, input logic v, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        if (who) begin
            bus.r1_req_valid = v; bus.r1_ctl = ctl; bus.r1_a = a; bus.r1_b = b;
        end else begin
            bus.r0_req_valid = v; bus.r0_ctl = ctl; bus.r0_a = a; bus.r0_b = b;
        end
    endtask

    task automatic wait_accept(input logic who, input string tag);
        logic acc = 1'b0;
        int   n = 0;
        while (!acc && n < 20) begin
            to_sample();
            acc = who ? (bus.r1_req_valid && bus.r1_req_ready) : (bus.r0_req_valid && bus.r0_req_ready);
            to_drive();
            n++;
        end
        chk({tag, "_accepted"}, {31'd0, acc}, 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            cycle();
            n++;
        end
        chk({tag, "_drained"}, sb.size(), 32'd0);
    endtask

    task automatic run_one(input logic who, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ed, input logic ez, input logic ee, input string tag);
        logic got = 1'b0;
        int   n = 0;
        set_req(who, 1'b1, ctl, a, b);
        wait_accept(who, tag);
        set_req(who, 1'b0, ctl, a, b);
        while (!got && n < 20) begin
            to_sample();
            if (who ? bus.r1_rsp_valid : bus.r0_rsp_valid) begin
                got = 1'b1;
                chk({tag, "_data"}, bus.rsp_data, ed);
                chk({tag, "_zero"}, {31'd0, bus.rsp_zero}, {31'd0, ez});
                chk({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, ee});
            end
            to_drive();
            n++;
        end
        chk({tag, "_rsp_seen"}, {31'd0, got}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_r0_req_ready"}, {31'd0, bus.r0_req_ready}, 32'd0);
        chk({tag, "_r1_req_ready"}, {31'd0, bus.r1_req_ready}, 32'd0);
        chk({tag, "_r0_rsp_valid"}, {31'd0, bus.r0_rsp_valid}, 32'd0);
        chk({tag, "_r1_rsp_valid"}, {31'd0, bus.r1_rsp_valid}, 32'd0);
        chk({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
        chk({tag, "_rsp_zero"}, {31'd0, bus.rsp_zero}, 32'd0);
        chk({tag, "_rsp_err"}, {31'd0, bus.rsp_err}, 32'd0);
        chk({tag, "_alu_ctl"}, {28'd0, bus.alu_ctl}, 32'd0);
        chk({tag, "_alu_a"}, bus.alu_a, 32'd0);
        chk({tag, "_alu_b"}, bus.alu_b, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        sb.delete();
        to_drive();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        set_req(1'b0, 1'b1, 4'd2, 32'd1, 32'd1);
        set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        bus.r0_rsp_ready = 1'b1;
        bus.r1_rsp_ready = 1'b1;

        // Reset state, with r0 already requesting: ready must stay low.
        reset = 1'b1;
        to_sample();
        check_reset_outputs("reset");
        to_drive();
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        reset = 1'b0;
        cycle();

        // Single request with latency checks.
        set_req(1'b0, 1'b1, ALU_ADD, 32'd5, 32'd7);
        to_sample();
        chk("single_ready", {31'd0, bus.r0_req_ready}, 32'd1);
        to_drive();
        set_req(1'b0, 1'b0, ALU_ADD, 32'd5, 32'd7);
        to_sample();
        chk("single_exec_busy", {31'd0, bus.busy}, 32'd1);
        chk("single_exec_no_rsp", {31'd0, bus.r0_rsp_valid}, 32'd0);
        chk("single_alu_ctl", {28'd0, bus.alu_ctl}, 32'd2);
        chk("single_alu_a", bus.alu_a, 32'd5);
        chk("single_alu_b", bus.alu_b, 32'd7);
        to_drive();
        to_sample();
        chk("single_r0_rsp_valid", {31'd0, bus.r0_rsp_valid}, 32'd1);
        chk("single_r1_rsp_valid", {31'd0, bus.r1_rsp_valid}, 32'd0);
        chk("single_data", bus.rsp_data, 32'd12);
        chk("single_zero", {31'd0, bus.rsp_zero}, 32'd0);
        chk("single_err", {31'd0, bus.rsp_err}, 32'd0);
        to_drive();
        to_sample();
        chk("single_back_idle", {31'd0, bus.busy}, 32'd0);
        to_drive();

        // Contention from a fresh pointer: r0, r1, r0.
        pulse_reset();
        grants.delete();
        set_req(1'b0, 1'b1, ALU_SUB, 32'd9, 32'd9);
        set_req(1'b1, 1'b1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        n = 0;
        while (grants.size() < 3 && n < 40) begin
            cycle();
            n++;
        end
        set_req(1'b0, 1'b0, ALU_SUB, 32'd9, 32'd9);
        set_req(1'b1, 1'b0, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        chk("contend_grant_count", grants.size(), 32'd3);
        if (grants.size() >= 3) begin
            chk("contend_grant0", grants[0], 32'd0);
            chk("contend_grant1", grants[1], 32'd1);
            chk("contend_grant2", grants[2], 32'd0);
        end
        drain("contend");

        // Response stall on r1; r0 knocks meanwhile.
        bus.r1_rsp_ready = 1'b0;
        set_req(1'b1, 1'b1, ALU_SLT, 32'd3, 32'd4);
        wait_accept(1'b1, "stall");
        set_req(1'b1, 1'b0, ALU_SLT, 32'd3, 32'd4);
        set_req(1'b0, 1'b1, ALU_ADD, 32'd1, 32'd1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            to_sample();
            chk("stall_rsp_valid", {31'd0, bus.r1_rsp_valid}, 32'd1);
            chk("stall_data", bus.rsp_data, 32'd1);
            chk("stall_no_accept", {31'd0, bus.r0_req_ready}, 32'd0);
            to_drive();
        end
        bus.r1_rsp_ready = 1'b1;
        to_sample();
        chk("stall_release_valid", {31'd0, bus.r1_rsp_valid}, 32'd1);
        chk("stall_release_no_accept", {31'd0, bus.r0_req_ready}, 32'd0);
        to_drive();
        to_sample();
        chk("stall_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("stall_idle_ready", {31'd0, bus.r0_req_ready}, 32'd1);
        to_drive();
        set_req(1'b0, 1'b0, ALU_ADD, 32'd1, 32'd1);
        drain("stall");

        // Unsupported code, wrap-around and NOR.
        run_one(1'b0, 4'd5, 32'd3, 32'd3, 32'd0, 1'b1, 1'b1, "unsup");
        run_one(1'b0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, "wrap");
        run_one(1'b1, ALU_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, "nor");
        run_one(1'b1, ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, "and");
        drain("ops");

        // Reset during EXEC.
        set_req(1'b0, 1'b1, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
        wait_accept(1'b0, "rexec");
        set_req(1'b0, 1'b0, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
        reset = 1'b1;
        sb.delete();
        to_sample();
        chk("rexec_busy_before", {31'd0, bus.busy}, 32'd1);
        to_drive();
        reset = 1'b0;
        to_sample();
        check_reset_outputs("rexec");
        to_drive();
        for (int i = 0; i < 4; i++) begin
            to_sample();
            chk("rexec_no_rsp", {31'd0, bus.r0_rsp_valid | bus.r1_rsp_valid}, 32'd0);
            to_drive();
        end

        // Reset during RESP.
        bus.r1_rsp_ready = 1'b0;
        set_req(1'b1, 1'b1, ALU_ADD, 32'd2, 32'd3);
        wait_accept(1'b1, "rresp");
        set_req(1'b1, 1'b0, ALU_ADD, 32'd2, 32'd3);
        cycle();
        to_sample();
        chk("rresp_valid_before", {31'd0, bus.r1_rsp_valid}, 32'd1);
        to_drive();
        reset = 1'b1;
        sb.delete();
        to_drive();
        reset = 1'b0;
        to_sample();
        check_reset_outputs("rresp");
        to_drive();
        bus.r1_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            to_sample();
            chk("rresp_no_rsp", {31'd0, bus.r0_rsp_valid | bus.r1_rsp_valid}, 32'd0);
            to_drive();
        end

        // First request after reset: r0 wins contention again.
        grants.delete();
        set_req(1'b0, 1'b1, ALU_ADD, 32'd10, 32'd20);
        set_req(1'b1, 1'b1, ALU_SUB, 32'd5, 32'd7);
        to_sample();
        chk("post_reset_r0_ready", {31'd0, bus.r0_req_ready}, 32'd1);
        chk("post_reset_r1_ready", {31'd0, bus.r1_req_ready}, 32'd0);
        to_drive();
        set_req(1'b0, 1'b0, ALU_ADD, 32'd10, 32'd20);
        n = 0;
        while (grants.size() < 2 && n < 40) begin
            cycle();
            n++;
        end
        set_req(1'b1, 1'b0, ALU_SUB, 32'd5, 32'd7);
        chk("post_reset_grant_count", grants.size(), 32'd2);
        if (grants.size() >= 2) chk("post_reset_second", grants[1], 32'd1);
        drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
